milano_csr_file: RTL and testbench
==================================

Name: milano_csr_file

Overview:
- Parametrised machine-mode CSR file for the milano core. Replaces the plain CSR register bank.
- Adds in-block read-modify-write (CSRRW/S/C), atomic trap entry and mret sequencing, and WARL field masking.
- Adds free-running 64-bit mcycle/minstret counters and live interrupt-pending aggregation with a priority-encoded request to ctrl.
- Sits between id (read), ex (CSR instructions) and ctrl (trap/mret, irq decision).

Parameters:
HART_ID, 32'h0, value returned by mhartid (read-only)
MISA_VAL, 32'h40000100, value returned by misa (RV32I, read-only)
MTVEC_RST, 32'h50, reset value of mtvec
MSTATUS_RST, 32'h8, reset value of mstatus (MIE=1)
MIE_RST, 32'h80, reset value of mie (MTIE=1)
CNT_EN, 1, 1 = mcycle/minstret count; 0 = counters hold (still writable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
id_raddr_i  in  12  CSR read address
id_rdata_o  out  32  CSR read data (combinational)
id_illegal_o  out  1  id_raddr_i is not an implemented CSR
ex_we_i  in  1  CSR instruction commit
ex_op_i  in  2  csr_op_e: WRITE, SET, CLEAR
ex_waddr_i  in  12  target CSR
ex_wdata_i  in  32  rs1/uimm operand
trap_i  in  1  take trap this cycle
trap_cause_i  in  32  mcause value
trap_pc_i  in  32  mepc value
trap_tval_i  in  32  mtval value
mret_i  in  1  execute mret
retire_i  in  1  one instruction retired
timer_irq_i  in  1  machine timer interrupt level
sw_irq_i  in  1  machine software interrupt level
ext_irq_i  in  1  machine external interrupt level
mstatus_o, mepc_o, mtvec_o, mie_o, mip_o  out  32 each  live register values to ctrl
irq_req_o  out  1  enabled interrupt pending
irq_cause_o  out  32  mcause value for the highest-priority pending interrupt

Behaviour:
- Reset (rst_ni=0 at posedge): mstatus=MSTATUS_RST, mtvec=MTVEC_RST, mie=MIE_RST. All other writable CSRs and both 64-bit counters are 0. mip is 0 until the first post-reset edge samples the irq inputs. Outputs follow, so irq_req_o=0 and irq_cause_o=0.
- RMW: new = WRITE ? wdata : SET ? old|wdata : old&~wdata. The new value is then WARL-masked and committed at the next posedge.
- WARL rules:
  - mtvec[1:0]=00 (direct mode only).
  - mepc[1:0]=00.
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] is hardwired to 11; all other bits are 0.
  - mie: only bits 3, 7, 11 are writable.
  - mip: read-only to software. Writes are accepted but have no effect.
- Read-only CSRs: mhartid and misa. Writes to them are ignored.
- Read bypass: if ex_we_i && ex_waddr_i==id_raddr_i, id_rdata_o is the masked new value. Otherwise it is the stored value. Unimplemented addresses read 0 with id_illegal_o=1.
- Write priority per cycle: trap_i > mret_i > ex_we_i. A lower-priority request in the same cycle is dropped entirely.
- Trap entry (one cycle, atomic): mepc=trap_pc_i&~3, mcause=trap_cause_i, mtval=trap_tval_i, MPIE=MIE, MIE=0.
- mret: MIE=MPIE, MPIE=1.
- mip: sampled every cycle, so pending bits have 1-cycle latency. MSIP[3]=sw_irq_i, MTIP[7]=timer_irq_i, MEIP[11]=ext_irq_i.
- irq_req_o = mstatus.MIE & |(mip & mie), combinational from registers.
- irq_cause_o priority is MEI > MSI > MTI: 0x8000000B / 0x80000003 / 0x80000007.
- Counters:
  - When CNT_EN=1, mcycle increments every cycle, and minstret increments when retire_i=1.
  - Increments are 64-bit with carry from the low to the high half; all-ones wraps to 0.
  - An ex write to either half of a counter in a cycle suppresses that counter's increment for that cycle.
  - On such a write, the written half takes the new value and the other half holds.
- Simultaneous trap_i with retire_i: minstret still increments.

Decomposition:
- milano_pkg gains:
  - csr_op_e.
  - mstatus bit-index localparams MIE/MPIE/MPP.
  - Interrupt cause constants IRQ_MSI/MTI/MEI.
- csr_num_e gains mcycleh/minstreth if absent.
- One sub-module: milano_csr_counter64. It is a 64-bit counter with inc_i, we_lo_i, we_hi_i and wdata_i, and is instantiated twice.

Test Plan:
- Reset release -> mstatus_o=0x1808 (MIE=1, MPP=11 hardwired), mtvec_o=0x50, mie_o=0x80, mcycle reads 0, then 1 a cycle later.
- CSRRS mstatus wdata=0x80 then CSRRC wdata=0x8 -> mstatus=0x1880. Same-cycle id read of mstatus returns 0x1880 via bypass.
- Write mtvec=0x1003 -> reads 0x1000. Write mip=0xFFFFFFFF -> mip unchanged. Read 0x7FF -> 0 with id_illegal_o=1.
- timer_irq_i=1 with MIE=1, mie=0x80 -> next cycle mip[7]=1, irq_req_o=1, irq_cause_o=0x80000007. Add ext_irq_i=1 -> irq_cause_o=0x8000000B.
- trap_i with pc=0x123, cause=0x80000007 plus same-cycle ex write to mstatus -> mepc=0x120, MIE=0, MPIE=1, ex write dropped. Then mret_i -> MIE=1, MPIE=1.
- Write mcycle=0xFFFFFFFF, mcycleh=0 -> next cycle low=0xFFFFFFFF (no increment), following cycle low=0 and high=1. minstret increments only on retire_i pulses.

Source files
------------

// File: rtl/milano_pkg.sv
// milano_pkg: shared CSR types and constants for the milano core.
//   csr_op_e    - CSR instruction operation (write / set / clear)
//   csr_num_e   - implemented machine-mode CSR addresses
//   MSTATUS_*   - mstatus bit indices and writable/hardwired masks
//   IRQ_*       - mcause values for machine interrupts
//   csr_rmw()   - read-modify-write combine of old value and operand
package milano_pkg;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MTVAL     = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_MHARTID   = 12'hF14
    } csr_num_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    localparam logic [31:0] IRQ_MSI = 32'h8000_0003;
    localparam logic [31:0] IRQ_MTI = 32'h8000_0007;
    localparam logic [31:0] IRQ_MEI = 32'h8000_000B;

    function automatic logic [31:0] csr_rmw(input csr_op_e op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
        case (op)
            CSR_WRITE: csr_rmw = wdata;
            CSR_SET:   csr_rmw = old_val | wdata;
            CSR_CLEAR: csr_rmw = old_val & ~wdata;
            default:   csr_rmw = old_val;
        endcase
    endfunction

endpackage

// File: rtl/milano_csr_counter64.sv
// milano_csr_counter64: 64-bit counter with independently writable halves.
//   clk_i, rst_ni     - clock, synchronous active-low reset (clears to 0)
//   inc_i             - increment by one this cycle
//   we_lo_i, we_hi_i  - load wdata_i into the low / high half
//   wdata_i           - load data
//   cnt_o             - current count
// A write to either half suppresses the increment; the other half holds.
module milano_csr_counter64
    import milano_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (we_lo_i) cnt_d[31:0]  = wdata_i;
        if (we_hi_i) cnt_d[63:32] = wdata_i;
        if (!we_lo_i && !we_hi_i && inc_i) cnt_d = cnt_q + 64'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/milano_csr_file.sv
// milano_csr_file: machine-mode CSR file for the milano core.
//   id_*    - combinational CSR read port (with same-cycle write bypass)
//   ex_*    - CSR instruction commit (CSRRW/S/C read-modify-write)
//   trap_*  - atomic trap entry (mepc/mcause/mtval/mstatus)
//   mret_i  - return from trap (restores MIE from MPIE)
//   retire_i, *_irq_i - minstret increment, interrupt levels
//   mstatus_o..mip_o  - live register values to ctrl
//   irq_req_o/irq_cause_o - enabled pending interrupt and its cause
module milano_csr_file
    import milano_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RST   = 32'h50,
    parameter logic [31:0] MSTATUS_RST = 32'h8,
    parameter logic [31:0] MIE_RST     = 32'h80,
    parameter bit          CNT_EN      = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] id_raddr_i,
    output logic [31:0] id_rdata_o,
    output logic        id_illegal_o,
    input  logic        ex_we_i,
    input  logic [1:0]  ex_op_i,
    input  logic [11:0] ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    input  logic        retire_i,
    input  logic        timer_irq_i,
    input  logic        sw_irq_i,
    input  logic        ext_irq_i,
    output logic [31:0] mstatus_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mie_o,
    output logic [31:0] mip_o,
    output logic        irq_req_o,
    output logic [31:0] irq_cause_o
);

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mip_q, mip_d;
    logic [63:0] mcycle, minstret;

    logic        ex_commit;
    logic [31:0] ex_old, ex_new;
    logic        ex_old_ok, id_ok;
    logic [31:0] id_stored;
    logic [31:0] irq_pend;

    // {implemented, value} for any CSR address
    function automatic logic [32:0] csr_lookup(input logic [11:0] a);
        case (a)
            CSR_MSTATUS:   csr_lookup = {1'b1, mstatus_q};
            CSR_MISA:      csr_lookup = {1'b1, MISA_VAL};
            CSR_MIE:       csr_lookup = {1'b1, mie_q};
            CSR_MTVEC:     csr_lookup = {1'b1, mtvec_q};
            CSR_MSCRATCH:  csr_lookup = {1'b1, mscratch_q};
            CSR_MEPC:      csr_lookup = {1'b1, mepc_q};
            CSR_MCAUSE:    csr_lookup = {1'b1, mcause_q};
            CSR_MTVAL:     csr_lookup = {1'b1, mtval_q};
            CSR_MIP:       csr_lookup = {1'b1, mip_q};
            CSR_MCYCLE:    csr_lookup = {1'b1, mcycle[31:0]};
            CSR_MINSTRET:  csr_lookup = {1'b1, minstret[31:0]};
            CSR_MCYCLEH:   csr_lookup = {1'b1, mcycle[63:32]};
            CSR_MINSTRETH: csr_lookup = {1'b1, minstret[63:32]};
            CSR_MHARTID:   csr_lookup = {1'b1, HART_ID};
            default:       csr_lookup = 33'd0;
        endcase
    endfunction

    // Read-only CSRs keep their old value, so the bypass shows "unchanged".
    function automatic logic [31:0] csr_warl(input logic [11:0] a,
                                             input logic [31:0] v,
                                             input logic [31:0] old_val);
        case (a)
            CSR_MSTATUS:                    csr_warl = (v & MSTATUS_WMASK) | MSTATUS_MPP;
            CSR_MTVEC, CSR_MEPC:            csr_warl = v & ~32'h3;
            CSR_MIE:                        csr_warl = v & MIE_WMASK;
            CSR_MIP, CSR_MISA, CSR_MHARTID: csr_warl = old_val;
            default:                        csr_warl = v;
        endcase
    endfunction

    always_comb begin
        {ex_old_ok, ex_old} = csr_lookup(ex_waddr_i);
        ex_new = csr_warl(ex_waddr_i,
                          csr_rmw(csr_op_e'(ex_op_i), ex_old, ex_wdata_i), ex_old);
    end

    always_comb begin
        {id_ok, id_stored} = csr_lookup(id_raddr_i);
        id_illegal_o = !id_ok;
        if (!id_ok)                                    id_rdata_o = '0;
        else if (ex_we_i && ex_waddr_i == id_raddr_i)  id_rdata_o = ex_new;
        else                                           id_rdata_o = id_stored;
    end

    assign ex_commit = ex_we_i && ex_old_ok && !trap_i && !mret_i;

    always_comb begin
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mie_d      = mie_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mip_d      = '0;
        mip_d[MIP_MSIP] = sw_irq_i;
        mip_d[MIP_MTIP] = timer_irq_i;
        mip_d[MIP_MEIP] = ext_irq_i;

        if (trap_i) begin
            mepc_d   = trap_pc_i & ~32'h3;
            mcause_d = trap_cause_i;
            mtval_d  = trap_tval_i;
            mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]  = 1'b0;
        end else if (mret_i) begin
            mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE] = 1'b1;
        end else if (ex_commit) begin
            case (ex_waddr_i)
                CSR_MSTATUS:  mstatus_d  = ex_new;
                CSR_MTVEC:    mtvec_d    = ex_new;
                CSR_MIE:      mie_d      = ex_new;
                CSR_MSCRATCH: mscratch_d = ex_new;
                CSR_MEPC:     mepc_d     = ex_new;
                CSR_MCAUSE:   mcause_d   = ex_new;
                CSR_MTVAL:    mtval_d    = ex_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mstatus_q  <= (MSTATUS_RST & MSTATUS_WMASK) | MSTATUS_MPP;
            mtvec_q    <= MTVEC_RST & ~32'h3;
            mie_q      <= MIE_RST & MIE_WMASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mie_q      <= mie_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
        end
    end

    milano_csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (CNT_EN),
        .we_lo_i (ex_commit && ex_waddr_i == CSR_MCYCLE),
        .we_hi_i (ex_commit && ex_waddr_i == CSR_MCYCLEH),
        .wdata_i (ex_new),
        .cnt_o   (mcycle)
    );

    // retire_i counts even during trap entry; only the ex write path is dropped.
    milano_csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (CNT_EN && retire_i),
        .we_lo_i (ex_commit && ex_waddr_i == CSR_MINSTRET),
        .we_hi_i (ex_commit && ex_waddr_i == CSR_MINSTRETH),
        .wdata_i (ex_new),
        .cnt_o   (minstret)
    );

    assign irq_pend  = mip_q & mie_q;
    assign irq_req_o = mstatus_q[MSTATUS_MIE] && (|irq_pend);

    always_comb begin
        if      (irq_pend[MIP_MEIP]) irq_cause_o = IRQ_MEI;
        else if (irq_pend[MIP_MSIP]) irq_cause_o = IRQ_MSI;
        else if (irq_pend[MIP_MTIP]) irq_cause_o = IRQ_MTI;
        else                         irq_cause_o = '0;
    end

    assign mstatus_o = mstatus_q;
    assign mepc_o    = mepc_q;
    assign mtvec_o   = mtvec_q;
    assign mie_o     = mie_q;
    assign mip_o     = mip_q;

endmodule

// File: tb/tb_milano_csr_file.sv
// tb_milano_csr_file: directed checks of milano_csr_file.
module tb_milano_csr_file;
    import milano_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [11:0] id_raddr_i = '0;
    logic [31:0] id_rdata_o;
    logic        id_illegal_o;
    logic        ex_we_i = 1'b0;
    logic [1:0]  ex_op_i = CSR_WRITE;
    logic [11:0] ex_waddr_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic        trap_i = 1'b0;
    logic [31:0] trap_cause_i = '0;
    logic [31:0] trap_pc_i = '0;
    logic [31:0] trap_tval_i = '0;
    logic        mret_i = 1'b0;
    logic        retire_i = 1'b0;
    logic        timer_irq_i = 1'b0;
    logic        sw_irq_i = 1'b0;
    logic        ext_irq_i = 1'b0;
    logic [31:0] mstatus_o, mepc_o, mtvec_o, mie_o, mip_o;
    logic        irq_req_o;
    logic [31:0] irq_cause_o;

    int n_cmp = 0;
    int n_mis = 0;

    milano_csr_file dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .id_raddr_i   (id_raddr_i),
        .id_rdata_o   (id_rdata_o),
        .id_illegal_o (id_illegal_o),
        .ex_we_i      (ex_we_i),
        .ex_op_i      (ex_op_i),
        .ex_waddr_i   (ex_waddr_i),
        .ex_wdata_i   (ex_wdata_i),
        .trap_i       (trap_i),
        .trap_cause_i (trap_cause_i),
        .trap_pc_i    (trap_pc_i),
        .trap_tval_i  (trap_tval_i),
        .mret_i       (mret_i),
        .retire_i     (retire_i),
        .timer_irq_i  (timer_irq_i),
        .sw_irq_i     (sw_irq_i),
        .ext_irq_i    (ext_irq_i),
        .mstatus_o    (mstatus_o),
        .mepc_o       (mepc_o),
        .mtvec_o      (mtvec_o),
        .mie_o        (mie_o),
        .mip_o        (mip_o),
        .irq_req_o    (irq_req_o),
        .irq_cause_o  (irq_cause_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Commit at the next posedge, then move 1 ns past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Combinational read of a CSR address, settled.
    task automatic rd(input logic [11:0] a);
        id_raddr_i = a;
        #1;
    endtask

    task automatic csr_op(input csr_op_e op, input logic [11:0] a, input logic [31:0] d);
        ex_we_i    = 1'b1;
        ex_op_i    = op;
        ex_waddr_i = a;
        ex_wdata_i = d;
        tick();
        ex_we_i = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        tick();
        tick();
        chk("rst_mstatus", mstatus_o, 32'h1808);
        chk("rst_mtvec", mtvec_o, 32'h50);
        chk("rst_mie", mie_o, 32'h80);
        chk("rst_mip", mip_o, 32'h0);
        chk("rst_irq_req", irq_req_o, 1'b0);
        chk("rst_irq_cause", irq_cause_o, 32'h0);

        rst_ni = 1'b1;
        rd(CSR_MCYCLE);
        chk("mcycle_0", id_rdata_o, 32'd0);
        tick();
        #1;
        chk("mcycle_1", id_rdata_o, 32'd1);

        // RMW with same-cycle bypass
        ex_we_i = 1'b1; ex_op_i = CSR_SET; ex_waddr_i = CSR_MSTATUS; ex_wdata_i = 32'h80;
        rd(CSR_MSTATUS);
        chk("set_bypass", id_rdata_o, 32'h1888);
        tick();
        ex_op_i = CSR_CLEAR; ex_wdata_i = 32'h8;
        #1;
        chk("clr_bypass", id_rdata_o, 32'h1880);
        tick();
        ex_we_i = 1'b0;
        chk("mstatus_rmw", mstatus_o, 32'h1880);

        // WARL
        csr_op(CSR_WRITE, CSR_MTVEC, 32'h1003);
        chk("mtvec_warl", mtvec_o, 32'h1000);
        rd(CSR_MTVEC);
        chk("mtvec_read", id_rdata_o, 32'h1000);
        csr_op(CSR_WRITE, CSR_MIP, 32'hFFFF_FFFF);
        chk("mip_ro", mip_o, 32'h0);
        rd(12'h7FF);
        chk("illegal_data", id_rdata_o, 32'h0);
        chk("illegal_flag", id_illegal_o, 1'b1);
        rd(CSR_MISA);
        chk("misa_flag", id_illegal_o, 1'b0);
        csr_op(CSR_WRITE, CSR_MISA, 32'h0);
        rd(CSR_MISA);
        chk("misa_ro", id_rdata_o, 32'h4000_0100);
        csr_op(CSR_WRITE, CSR_MSTATUS, 32'hFFFF_FFFF);
        chk("mstatus_warl", mstatus_o, 32'h1888);
        csr_op(CSR_WRITE, CSR_MIE, 32'hFFFF_FFFF);
        chk("mie_warl", mie_o, 32'h888);
        csr_op(CSR_WRITE, CSR_MIE, 32'h880);

        // interrupts
        timer_irq_i = 1'b1;
        #1;
        chk("irq_latency", irq_req_o, 1'b0);
        tick();
        chk("mip_mtip", mip_o, 32'h80);
        chk("irq_req_t", irq_req_o, 1'b1);
        chk("cause_mti", irq_cause_o, 32'h8000_0007);
        ext_irq_i = 1'b1;
        sw_irq_i  = 1'b1;
        tick();
        chk("mip_all", mip_o, 32'h888);
        chk("cause_mei", irq_cause_o, 32'h8000_000B);
        timer_irq_i = 1'b0; ext_irq_i = 1'b0; sw_irq_i = 1'b0;
        tick();
        chk("irq_clear", irq_req_o, 1'b0);

        // trap entry beats a same-cycle ex write; minstret still counts
        rd(CSR_MINSTRET);
        chk("minstret_0", id_rdata_o, 32'd0);
        trap_i = 1'b1; trap_pc_i = 32'h123; trap_cause_i = 32'h8000_0007;
        trap_tval_i = 32'hDEAD; retire_i = 1'b1;
        csr_op(CSR_WRITE, CSR_MSTATUS, 32'h0);
        trap_i = 1'b0; retire_i = 1'b0;
        chk("trap_mepc", mepc_o, 32'h120);
        chk("trap_mstatus", mstatus_o, 32'h1880);
        rd(CSR_MCAUSE);
        chk("trap_mcause", id_rdata_o, 32'h8000_0007);
        rd(CSR_MTVAL);
        chk("trap_mtval", id_rdata_o, 32'hDEAD);
        rd(CSR_MINSTRET);
        chk("minstret_trap", id_rdata_o, 32'd1);

        mret_i = 1'b1;
        csr_op(CSR_WRITE, CSR_MEPC, 32'h0);
        mret_i = 1'b0;
        chk("mret_mstatus", mstatus_o, 32'h1888);
        chk("mret_mepc", mepc_o, 32'h120);

        // counter carry across halves
        csr_op(CSR_WRITE, CSR_MCYCLE, 32'hFFFF_FFFF);
        csr_op(CSR_WRITE, CSR_MCYCLEH, 32'h0);
        rd(CSR_MCYCLE);
        chk("mcycle_hold", id_rdata_o, 32'hFFFF_FFFF);
        rd(CSR_MCYCLEH);
        chk("mcycleh_hold", id_rdata_o, 32'h0);
        tick();
        rd(CSR_MCYCLE);
        chk("mcycle_wrap", id_rdata_o, 32'h0);
        rd(CSR_MCYCLEH);
        chk("mcycleh_carry", id_rdata_o, 32'h1);

        // minstret only on retire pulses
        retire_i = 1'b1; tick();
        retire_i = 1'b0; tick();
        rd(CSR_MINSTRET);
        chk("minstret_2", id_rdata_o, 32'd2);
        tick();
        retire_i = 1'b1; tick();
        retire_i = 1'b0;
        rd(CSR_MINSTRET);
        chk("minstret_3", id_rdata_o, 32'd3);
        retire_i = 1'b1;
        csr_op(CSR_WRITE, CSR_MINSTRET, 32'h10);
        retire_i = 1'b0;
        rd(CSR_MINSTRET);
        chk("minstret_wr", id_rdata_o, 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
